led_seq_ctrl: RTL and testbench

//   Multi-channel LED sequencer/controller for the board status LEDs. Generates a shared

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/led_seq_chan.sv | 111 +++++++++++
 rtl/led_seq_ctrl.sv | 111 +++++++++++
 tb/tb_led_seq_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encoding, channel FSM states and
// sizing helpers used by led_seq_ctrl and led_seq_chan.
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        StIdleOff,
        StSolidOn,
        StPhOn,
        StPhOff
    } chan_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/led_seq_chan.sv
// One LED channel: OFF/ON/BLINK/BURST sequencer with phase and burst counters.
// Advances only on the shared tick; a load always takes priority over sequencing.
module led_seq_chan
    import led_seq_pkg::*;
#(
    parameter int unsigned PER_W = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tick,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic [PER_W-1:0] on_len,
    input  logic [PER_W-1:0] off_len,
    input  logic [CNT_W-1:0] burst,
    output logic             led_on,
    output logic             busy,
    output logic             done_pulse
);

    chan_state_e      state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] on_q, on_d;
    logic [PER_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             is_burst_q, is_burst_d;
    logic             led_q, led_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        on_d       = on_q;
        off_d      = off_q;
        rem_d      = rem_q;
        is_burst_d = is_burst_q;
        done_d     = 1'b0;

        if (load) begin
            cnt_d      = '0;
            on_d       = (on_len == '0) ? PER_W'(1) : on_len;
            off_d      = (off_len == '0) ? PER_W'(1) : off_len;
            rem_d      = (burst == '0) ? CNT_W'(1) : burst;
            is_burst_d = (mode == MODE_BURST);
            case (mode)
                MODE_OFF: state_d = StIdleOff;
                MODE_ON:  state_d = StSolidOn;
                default:  state_d = StPhOn;
            endcase
        end else if (tick) begin
            unique case (state_q)
                StPhOn: begin
                    if (cnt_q == on_q - 1'b1) begin
                        state_d = StPhOff;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPhOff: begin
                    if (cnt_q == off_q - 1'b1) begin
                        cnt_d   = '0;
                        state_d = StPhOn;
                        if (is_burst_q) begin
                            // Last OFF phase of a burst: retire and flag completion.
                            if (rem_q == CNT_W'(1)) begin
                                state_d = StIdleOff;
                                done_d  = 1'b1;
                            end
                            rem_d = rem_q - 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        led_d = enable && ((state_d == StSolidOn) || (state_d == StPhOn));
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdleOff;
            cnt_q      <= '0;
            on_q       <= PER_W'(1);
            off_q      <= PER_W'(1);
            rem_q      <= CNT_W'(1);
            is_burst_q <= 1'b0;
            led_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            on_q       <= on_d;
            off_q      <= off_d;
            rem_q      <= rem_d;
            is_burst_q <= is_burst_d;
            led_q      <= led_d;
            done_q     <= done_d;
        end
    end

    assign led_on     = led_q;
    assign busy       = (state_q == StPhOn) || (state_q == StPhOff);
    assign done_pulse = done_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Multi-channel LED sequencer top: tick prescaler, enable path, config handshake and decode.
// Define LED_SEQ_SWSYNC_EN to pass switch_on through a 2-flop synchronizer.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned PER_W   = 16,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          switch_on,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
    input  logic [1:0]                    cfg_mode,
    input  logic [PER_W-1:0]              cfg_on,
    input  logic [PER_W-1:0]              cfg_off,
    input  logic [CNT_W-1:0]              cfg_burst,
    output logic                          cfg_err,
    output logic [NUM_CH-1:0]             led_on,
    output logic [NUM_CH-1:0]             busy,
    output logic [NUM_CH-1:0]             done_pulse
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PRE_W = $clog2(DIV);

    logic              enable;
    logic              tick;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              commit_q, commit_d;
    logic              cfg_err_q, cfg_err_d;
    logic              accept;
    logic              ch_valid;
    logic [NUM_CH-1:0] load;

`ifdef LED_SEQ_SWSYNC_EN
    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], switch_on};
    assign enable = sync_q[1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign enable = switch_on;
`endif

    always_comb begin
        // The cycle after an accepted write is a commit cycle with cfg_ready low.
        accept    = cfg_valid && !commit_q;
        ch_valid  = 32'(cfg_ch) < NUM_CH;
        commit_d  = accept;
        cfg_err_d = cfg_err_q || (accept && !ch_valid);

        tick = enable && (pre_q == PRE_W'(DIV - 1));
        if (!enable || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            load[i] = accept && (32'(cfg_ch) == i);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            commit_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            commit_q  <= commit_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ready = !commit_q;
    assign cfg_err   = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        led_seq_chan #(
            .PER_W(PER_W),
            .CNT_W(CNT_W)
        ) u_chan (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .enable    (enable),
            .tick      (tick),
            .load      (load[g]),
            .mode      (cfg_mode),
            .on_len    (cfg_on),
            .off_len   (cfg_off),
            .burst     (cfg_burst),
            .led_on    (led_on[g]),
            .busy      (busy[g]),
            .done_pulse(done_pulse[g])
        );
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus randomized traffic,
// compared against a tick-count reference model.
module tb_led_seq_ctrl;

    localparam int NCH     = 4;
    localparam int DIV     = 10;
    localparam int M_OFF   = 0;
    localparam int M_ON    = 1;
    localparam int M_BLINK = 2;
    localparam int M_BURST = 3;
`ifdef LED_SEQ_SWSYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        switch_on = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch    = '0;
    logic [1:0]  cfg_mode  = '0;
    logic [15:0] cfg_on    = '0;
    logic [15:0] cfg_off   = '0;
    logic [3:0]  cfg_burst = '0;
    logic        cfg_ready, cfg_err;
    logic [3:0]  led_on, busy, done_pulse;

    // A 4-channel build cannot address an out-of-range channel, so a 3-channel copy covers that.
    logic        c3_valid = 1'b0;
    logic [1:0]  c3_ch    = '0;
    logic        c3_ready, c3_err;
    logic [2:0]  c3_led, c3_busy, c3_done;

    int n_tests = 0;
    int n_fail  = 0;

    led_seq_ctrl #(.NUM_CH(4), .CLK_HZ(100), .TICK_HZ(10), .PER_W(16), .CNT_W(4)) u_dut (
        .clk_in(clk), .rst_n(rst_n), .switch_on(switch_on), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on),
        .cfg_off(cfg_off), .cfg_burst(cfg_burst), .cfg_err(cfg_err), .led_on(led_on),
        .busy(busy), .done_pulse(done_pulse)
    );

    led_seq_ctrl #(.NUM_CH(3), .CLK_HZ(100), .TICK_HZ(10), .PER_W(16), .CNT_W(4)) u_dut3 (
        .clk_in(clk), .rst_n(rst_n), .switch_on(switch_on), .cfg_valid(c3_valid),
        .cfg_ready(c3_ready), .cfg_ch(c3_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on),
        .cfg_off(cfg_off), .cfg_burst(cfg_burst), .cfg_err(c3_err), .led_on(c3_led),
        .busy(c3_busy), .done_pulse(c3_done)
    );

    initial forever #5 clk = ~clk;

    // Reference model: each channel tracks ticks elapsed since its load; LED state
    // follows from (ticks mod period) and burst completion from ticks == count*period.
    int         m_mode [NCH];
    int         m_on   [NCH];
    int         m_off  [NCH];
    int         m_bn   [NCH];
    int         m_k    [NCH];
    bit         m_fin  [NCH];
    logic [3:0] m_led, m_busy, m_done;
    bit         m_ready, m_en, m_tick, m_acc, m_act, m_s1, m_s2;
    int         m_pre;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 0; m_ready = 1'b1; m_s1 = 1'b0; m_s2 = 1'b0;
            m_led = '0; m_busy = '0; m_done = '0;
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = M_OFF; m_k[c] = 0; m_fin[c] = 1'b0;
                m_on[c] = 1; m_off[c] = 1; m_bn[c] = 1;
            end
        end else begin
`ifdef LED_SEQ_SWSYNC_EN
            m_en = m_s2; m_s2 = m_s1; m_s1 = switch_on;
`else
            m_en = switch_on;
`endif
            m_tick  = m_en && (m_pre == DIV - 1);
            m_acc   = cfg_valid && m_ready;
            m_pre   = (!m_en || m_pre == DIV - 1) ? 0 : m_pre + 1;
            m_ready = !m_acc;
            for (int c = 0; c < NCH; c++) begin
                m_done[c] = 1'b0;
                m_act = (m_mode[c] == M_BLINK) || (m_mode[c] == M_BURST && !m_fin[c]);
                if (m_acc && int'(cfg_ch) == c) begin
                    m_mode[c] = int'(cfg_mode);
                    m_on[c]   = (cfg_on == 0) ? 1 : int'(cfg_on);
                    m_off[c]  = (cfg_off == 0) ? 1 : int'(cfg_off);
                    m_bn[c]   = (cfg_burst == 0) ? 1 : int'(cfg_burst);
                    m_k[c]    = 0;
                    m_fin[c]  = 1'b0;
                end else if (m_tick && m_act) begin
                    m_k[c]++;
                    if (m_mode[c] == M_BURST && m_k[c] == m_bn[c] * (m_on[c] + m_off[c])) begin
                        m_fin[c]  = 1'b1;
                        m_done[c] = 1'b1;
                    end
                end
                m_act = (m_mode[c] == M_BLINK) || (m_mode[c] == M_BURST && !m_fin[c]);
                m_busy[c] = m_act;
                m_led[c]  = m_en && (m_mode[c] == M_ON ||
                            (m_act && (m_k[c] % (m_on[c] + m_off[c])) < m_on[c]));
            end
        end
    end

    task automatic do_write(input int ch, input int mode, input int on, input int off,
                            input int bn);
        bit ok = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
        cfg_on = 16'(on); cfg_off = 16'(off); cfg_burst = 4'(bn);
        for (int i = 0; i < 4 && !ok; i++) begin
            ok = cfg_ready;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_accept ch=%0d: cfg_ready stayed 0, required acceptance", ch);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (led_on !== 4'b0 || busy !== 4'b0 || done_pulse !== 4'b0 || cfg_ready !== 1'b1 ||
            cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: led=%b busy=%b done=%b rdy=%b err=%b, required 0 0 0 1 0",
                     led_on, busy, done_pulse, cfg_ready, cfg_err);
        end
        @(negedge clk);
        rst_n = 1'b1; switch_on = 1'b1;
        do_write(0, M_BLINK, 2, 3, 0);
        repeat (25) @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy: busy[0]=%b, required 1", busy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (led_on !== 4'b0 || busy !== 4'b0 || cfg_ready !== 1'b1 || done_pulse !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset: led=%b busy=%b done=%b rdy=%b, required 0 0 0 1",
                     led_on, busy, done_pulse, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (led_on !== 4'b0 || busy !== 4'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_release: led=%b busy=%b rdy=%b, required 0 0 1",
                     led_on, busy, cfg_ready);
        end
    endtask

    task automatic test_on();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'(M_ON);
        cfg_on = 16'd1; cfg_off = 16'd1; cfg_burst = 4'd1;
        n_tests++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL on_ready_T: cfg_ready=%b, required 1", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        n_tests++;
        if (led_on[1] !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL on_T1: led_on[1]=%b cfg_ready=%b, required 1 0", led_on[1], cfg_ready);
        end
        @(negedge clk);
        n_tests++;
        if (cfg_ready !== 1'b1 || led_on[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL on_T2: cfg_ready=%b led_on[1]=%b, required 1 1", cfg_ready, led_on[1]);
        end
        do_write(1, M_OFF, 1, 1, 1);
        n_tests++;
        if (led_on[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL off_write: led_on[1]=%b, required 0", led_on[1]);
        end
    endtask

    task automatic test_blink();
        logic tr [200];
        int f0 = -1, r1 = -1, f1 = -1, r2 = -1;
        do_write(0, M_BLINK, 2, 3, 0);
        for (int i = 0; i < 200; i++) begin
            tr[i] = led_on[0];
            n_tests++;
            if (led_on !== m_led || busy !== m_busy || done_pulse !== m_done) begin
                n_fail++;
                $display("FAIL blink_model cyc=%0d: led=%b busy=%b done=%b, required %b %b %b",
                         i, led_on, busy, done_pulse, m_led, m_busy, m_done);
            end
            @(negedge clk);
        end
        for (int i = 1; i < 200; i++) begin
            if (tr[i-1] && !tr[i]) begin
                if (f0 < 0) f0 = i;
                else if (r1 >= 0 && f1 < 0) f1 = i;
            end
            if (!tr[i-1] && tr[i] && f0 >= 0) begin
                if (r1 < 0) r1 = i;
                else if (f1 >= 0 && r2 < 0) r2 = i;
            end
        end
        n_tests++;
        if (r1 < 0 || f1 < 0 || r2 < 0 || (f1 - r1) != 20 || (r2 - f1) != 30) begin
            n_fail++;
            $display("FAIL blink_period: high=%0d low=%0d cycles, required 20 30",
                     f1 - r1, r2 - f1);
        end
    endtask

    task automatic test_burst();
        int   rises = 0, dones = 0;
        logic prev;
        do_write(2, M_BURST, 1, 1, 3);
        prev  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (led_on[2] && !prev) rises++;
            if (done_pulse[2]) dones++;
            prev = led_on[2];
            n_tests++;
            if (led_on !== m_led || busy !== m_busy || done_pulse !== m_done) begin
                n_fail++;
                $display("FAIL burst_model cyc=%0d: led=%b busy=%b done=%b, required %b %b %b",
                         i, led_on, busy, done_pulse, m_led, m_busy, m_done);
            end
            @(negedge clk);
        end
        n_tests++;
        if (rises != 3 || dones != 1 || led_on[2] !== 1'b0 || busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_summary: pulses=%0d dones=%0d led=%b busy=%b, required 3 1 0 0",
                     rises, dones, led_on[2], busy[2]);
        end
    endtask

    task automatic test_enable();
        switch_on = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            n_tests++;
            if (led_on !== m_led || busy !== m_busy || done_pulse !== m_done ||
                (i >= LAT && led_on !== 4'b0)) begin
                n_fail++;
                $display("FAIL disable cyc=%0d: led=%b busy=%b, required %b %b (led 0 from %0d)",
                         i, led_on, busy, m_led, m_busy, LAT);
            end
        end
        do_write(3, M_ON, 1, 1, 1);
        n_tests++;
        if (led_on[3] !== 1'b0 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL frozen_load: led_on[3]=%b busy[0]=%b, required 0 1", led_on[3], busy[0]);
        end
        switch_on = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            n_tests++;
            if (led_on !== m_led || busy !== m_busy || done_pulse !== m_done ||
                (i == LAT && led_on[3] !== 1'b1)) begin
                n_fail++;
                $display("FAIL resume cyc=%0d: led=%b busy=%b done=%b, required %b %b %b",
                         i, led_on, busy, done_pulse, m_led, m_busy, m_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'(((i / 2) % 2) ? M_BLINK : M_ON);
            cfg_on = 16'd2; cfg_off = 16'd2; cfg_burst = 4'd0;
            if (cfg_ready) acc++;
            @(negedge clk);
            n_tests++;
            if (cfg_ready !== 1'(i % 2) || led_on !== m_led || busy !== m_busy) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d: rdy=%b led=%b busy=%b, required %b %b %b",
                         i, cfg_ready, led_on, busy, 1'(i % 2), m_led, m_busy);
            end
        end
        cfg_valid = 1'b0;
        n_tests++;
        if (acc != 4) begin
            n_fail++;
            $display("FAIL b2b_accepts: %0d accepted, required 4", acc);
        end
    endtask

    task automatic test_cfg_err();
        cfg_mode = 2'(M_ON); cfg_on = 16'd1; cfg_off = 16'd1; cfg_burst = 4'd1;
        c3_valid = 1'b1; c3_ch = 2'd3;
        n_tests++;
        if (c3_ready !== 1'b1 || c3_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pre: rdy=%b err=%b, required 1 0", c3_ready, c3_err);
        end
        @(negedge clk);
        c3_valid = 1'b0;
        n_tests++;
        if (c3_err !== 1'b1 || c3_ready !== 1'b0 || c3_led !== 3'b0) begin
            n_fail++;
            $display("FAIL err_set: err=%b rdy=%b led=%b, required 1 0 000", c3_err, c3_ready, c3_led);
        end
        repeat (20) @(negedge clk);
        c3_valid = 1'b1; c3_ch = 2'd2;
        @(negedge clk);
        c3_valid = 1'b0;
        n_tests++;
        if (c3_err !== 1'b1 || c3_led !== 3'b100 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b led=%b main_err=%b, required 1 100 0",
                     c3_err, c3_led, cfg_err);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (c3_err !== 1'b0 || c3_led !== 3'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b led=%b, required 0 000", c3_err, c3_led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            n_tests++;
            if (led_on !== m_led || busy !== m_busy || done_pulse !== m_done ||
                cfg_ready !== m_ready) begin
                n_fail++;
                $display("FAIL random cyc=%0d: led=%b busy=%b done=%b rdy=%b, required %b %b %b %b",
                         i, led_on, busy, done_pulse, cfg_ready, m_led, m_busy, m_done, m_ready);
            end
            if ($urandom_range(0, 59) == 0) switch_on = ~switch_on;
            cfg_valid = ($urandom_range(0, 11) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_on    = 16'($urandom_range(0, 3));
            cfg_off   = 16'($urandom_range(0, 3));
            cfg_burst = 4'($urandom_range(0, 3));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        switch_on = 1'b1;
    endtask

    initial begin
        test_reset();
        test_on();
        test_blink();
        test_burst();
        test_enable();
        test_back_to_back();
        test_cfg_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
